output_display: RTL and testbench

- Downstream consumer of the CPU's 8-bit output register; drives a 3-digit common-anode 7-segment display.
- Converts the binary value to BCD with a sequential double-dabble engine: one bit per clock, no divider.
- Time-multiplexes the three digits at a programmable refresh rate.
- Suppresses leading zeros.

---
 rtl/output_display.sv | 160 ++++++++++++++++
 tb/tb_output_display.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/output_display.sv
// 8-bit binary to 3-digit multiplexed common-anode 7-segment driver.
// Sequential double-dabble BCD conversion, one bit per clock, with optional leading-zero blanking.
module output_display #(
    parameter int REFRESH_DIV   = 1000,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  value,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic [11:0] bcd,
    output logic        busy
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_done;
    logic [7:0]         r_src;
    logic [19:0]        r_scratch;
    logic [19:0]        w_shifted;
    logic [2:0]         r_bit_cnt;
    logic [11:0]        r_bcd;
    logic               r_busy;
    logic [CNT_W-1:0]   r_ref_cnt;
    logic               w_ref_wrap;
    logic [1:0]         r_idx;
    logic [1:0]         w_sel_idx;
    logic [3:0]         w_nib;
    logic               w_blank;
    logic [6:0]         r_seg;
    logic [2:0]         r_an;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Adjust all three BCD nibbles, then shift; the hundreds carry-out falls off the top.
    assign w_shifted = 20'({add3(r_scratch[19:16]), add3(r_scratch[15:12]),
                            add3(r_scratch[11:8]), r_scratch[7:0], 1'b0});

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (value != r_src) begin
                    w_state_nxt = S_SHIFT;
                    w_load      = 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_bit_cnt == 3'd7) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_src     <= 8'd0;
            r_scratch <= 20'd0;
            r_bit_cnt <= 3'd0;
            r_bcd     <= 12'h000;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_src     <= value;
                r_scratch <= {12'h000, value};
                r_bit_cnt <= 3'd0;
                r_busy    <= 1'b1;
            end else if (r_state == S_SHIFT) begin
                r_scratch <= w_shifted;
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (w_done) begin
                    r_bcd  <= w_shifted[19:8];
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign w_ref_wrap = (r_ref_cnt == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_cnt <= '0;
            r_idx     <= 2'd0;
        end else if (w_ref_wrap) begin
            r_ref_cnt <= '0;
            r_idx     <= (r_idx >= 2'd2) ? 2'd0 : r_idx + 2'd1;
        end else begin
            r_ref_cnt <= r_ref_cnt + CNT_W'(1);
        end
    end

    // Only the committed result is displayed, never the in-flight scratch.
    always_comb begin
        w_sel_idx = (r_idx == 2'd3) ? 2'd0 : r_idx;
        w_nib     = r_bcd[3:0];
        w_blank   = 1'b0;
        case (w_sel_idx)
            2'd1: begin
                w_nib   = r_bcd[7:4];
                w_blank = (BLANK_LEADING != 0) && (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
            end
            2'd2: begin
                w_nib   = r_bcd[11:8];
                w_blank = (BLANK_LEADING != 0) && (r_bcd[11:8] == 4'd0);
            end
            default: begin
                w_nib   = r_bcd[3:0];
                w_blank = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= 7'b1111111;
            r_an  <= 3'b111;
        end else begin
            r_an  <= ~(3'b001 << w_sel_idx);
            r_seg <= w_blank ? 7'b1111111 : seg7(w_nib);
        end
    end

    assign seg  = r_seg;
    assign an   = r_an;
    assign bcd  = r_bcd;
    assign busy = r_busy;

endmodule

// File: tb/tb_output_display.sv
// Directed self-checking bench for output_display: two instances (blanking on/off) share stimulus.
module tb_output_display;

    logic        clk;
    logic        rst_n;
    logic [7:0]  value;
    logic [6:0]  seg_b, seg_n;
    logic [2:0]  an_b, an_n;
    logic [11:0] bcd_b, bcd_n;
    logic        busy_b, busy_n;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SB = 7'b1111111;

    output_display #(.REFRESH_DIV(4), .BLANK_LEADING(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .value(value),
        .seg(seg_b), .an(an_b), .bcd(bcd_b), .busy(busy_b)
    );

    output_display #(.REFRESH_DIV(4), .BLANK_LEADING(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .value(value),
        .seg(seg_n), .an(an_n), .bcd(bcd_n), .busy(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts stepping at the edge that samples the new value; returns busy-high cycle count.
    task automatic wait_conv(output int hi);
        int t;
        hi = 0;
        t  = 0;
        step();
        while (!busy_b && t < 5) begin
            step();
            t++;
        end
        while (busy_b && hi < 20) begin
            hi++;
            step();
        end
    endtask

    task automatic capture(output logic [6:0] o_b, output logic [6:0] t_b, output logic [6:0] h_b,
                           output logic [6:0] o_n, output logic [6:0] t_n, output logic [6:0] h_n);
        o_b = 'x; t_b = 'x; h_b = 'x; o_n = 'x; t_n = 'x; h_n = 'x;
        for (int i = 0; i < 12; i++) begin
            step();
            case (an_b)
                3'b110:  o_b = seg_b;
                3'b101:  t_b = seg_b;
                3'b011:  h_b = seg_b;
                default: ;
            endcase
            case (an_n)
                3'b110:  o_n = seg_n;
                3'b101:  t_n = seg_n;
                3'b011:  h_n = seg_n;
                default: ;
            endcase
        end
    endtask

    initial begin
        int hi;
        logic [6:0] ob, tb, hb, on, tn, hn;
        logic [11:0] exp_bcd;

        rst_n = 1'b0;
        value = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 12'(busy_b), 12'd0);
        chk("rst_bcd", bcd_b, 12'h000);
        chk("rst_seg", 12'(seg_b), 12'(SB));
        chk("rst_an", 12'(an_b), 12'(3'b111));

        // Refresh scan with value 0: no conversion, ones shows 0.
        rst_n = 1'b1;
        step();
        chk("scan_e1_an", 12'(an_b), 12'(3'b110));
        chk("scan_e1_seg", 12'(seg_b), 12'(S0));
        chk("scan_e1_busy", 12'(busy_b), 12'd0);
        repeat (3) step();
        chk("scan_e4_an", 12'(an_b), 12'(3'b110));
        step();
        chk("scan_e5_an", 12'(an_b), 12'(3'b101));
        chk("scan_e5_seg_blank", 12'(seg_b), 12'(SB));
        chk("scan_e5_seg_noblank", 12'(seg_n), 12'(S0));
        repeat (4) step();
        chk("scan_e9_an", 12'(an_b), 12'(3'b011));
        chk("scan_e9_seg", 12'(seg_b), 12'(SB));
        chk("scan_e9_busy", 12'(busy_b), 12'd0);
        chk("scan_e9_bcd", bcd_b, 12'h000);
        repeat (4) step();
        chk("scan_e13_an", 12'(an_b), 12'(3'b110));

        value = 8'd255;
        wait_conv(hi);
        chk("c255_busy_cycles", 12'(hi), 12'd8);
        chk("c255_bcd", bcd_b, 12'h255);
        capture(ob, tb, hb, on, tn, hn);
        chk("c255_ones", 12'(ob), 12'(S5));
        chk("c255_tens", 12'(tb), 12'(S5));
        chk("c255_hund", 12'(hb), 12'(S2));

        value = 8'd7;
        wait_conv(hi);
        chk("c7_busy_cycles", 12'(hi), 12'd8);
        chk("c7_bcd", bcd_b, 12'h007);
        capture(ob, tb, hb, on, tn, hn);
        chk("c7_ones", 12'(ob), 12'(S7));
        chk("c7_tens_blank", 12'(tb), 12'(SB));
        chk("c7_hund_blank", 12'(hb), 12'(SB));
        chk("c7_ones_nb", 12'(on), 12'(S7));
        chk("c7_tens_nb", 12'(tn), 12'(S0));
        chk("c7_hund_nb", 12'(hn), 12'(S0));

        // 100 then 42 three cycles into the conversion.
        value = 8'd100;
        step();
        chk("ovl_e0_busy", 12'(busy_b), 12'd1);
        repeat (3) step();
        value = 8'd42;
        repeat (4) step();
        chk("ovl_e7_busy", 12'(busy_b), 12'd1);
        chk("ovl_e7_bcd_old", bcd_b, 12'h007);
        step();
        chk("ovl_e8_busy", 12'(busy_b), 12'd0);
        chk("ovl_e8_bcd", bcd_b, 12'h100);
        step();
        chk("ovl_e9_busy", 12'(busy_b), 12'd1);
        chk("ovl_e9_bcd", bcd_b, 12'h100);
        repeat (7) step();
        chk("ovl_e16_busy", 12'(busy_b), 12'd1);
        step();
        chk("ovl_e17_busy", 12'(busy_b), 12'd0);
        chk("ovl_e17_bcd", bcd_b, 12'h042);

        // Reset in the middle of converting 200.
        value = 8'd200;
        step();
        repeat (4) step();
        chk("mid_busy_pre", 12'(busy_b), 12'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 12'(busy_b), 12'd0);
        chk("mid_rst_bcd", bcd_b, 12'h000);
        chk("mid_rst_an", 12'(an_b), 12'(3'b111));
        chk("mid_rst_seg", 12'(seg_b), 12'(SB));
        step();
        rst_n = 1'b1;
        wait_conv(hi);
        chk("c200_busy_cycles", 12'(hi), 12'd8);
        chk("c200_bcd", bcd_b, 12'h200);
        chk("c200_bcd_nb", bcd_n, 12'h200);

        for (int v = 0; v < 256; v++) begin
            value = 8'(v);
            wait_conv(hi);
            exp_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            chk($sformatf("sweep_%0d", v), bcd_b, exp_bcd);
            chk($sformatf("sweep_hund_%0d", v), 12'(bcd_b[11:8] <= 4'd2), 12'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
